// File: rtl/spi_reg_responder_if.sv
// Local configuration bus for spi_reg_responder: access strobe, write select,
// register index, write data and registered read data.
interface spi_reg_responder_if #(
    parameter int ADDR_WIDTH = 2
);
    logic                  enable;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] address;
    logic [7:0]            write_data;
    logic [7:0]            read_data;

    modport master (
        output enable, write_enable, address, write_data,
        input  read_data
    );

    modport slave (
        input  enable, write_enable, address, write_data,
        output read_data
    );
endinterface

// File: rtl/spi_reg_responder.sv
// SPI mode-0 register-file responder with a shared local register bus.
// Define SPI_REG_RESPONDER_BURST_EN to let bytes after the first data byte auto-increment the address.
module spi_reg_responder #(
    parameter int ADDR_WIDTH  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    spi_reg_responder_if.slave bus,
    input  logic               sclk_i,
    input  logic               cs_i,
    input  logic               sdi,
    output logic               sdo,
    output logic               done_int
);
    localparam int REG_COUNT = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = 1;
`ifdef SPI_REG_RESPONDER_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        WAIT_CS,
        IDLE,
        CMD,
        DATA,
        EXTRA
    } state_t;

    logic [SYNC_STAGES-1:0] sclkSync_q, csSync_q, sdiSync_q;
    logic                   sclkPrev_q, csPrev_q;
    logic                   sclkS, csS, sdiS;
    logic                   sclkRise, sclkFall, csRise, csFall;

    state_t                state_q, state_d;
    logic [2:0]            bitCnt_q, bitCnt_d;
    logic [7:0]            rxShift_q, rxShift_d;
    logic [7:0]            txShift_q, txShift_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  isRead_q, isRead_d;
    logic                  oor_q, oor_d;
    logic                  dataDone_q, dataDone_d;
    logic                  sdo_q, sdo_d;
    logic                  done_q, done_d;

    logic [7:0]            regs_q [REG_COUNT];
    logic [7:0]            readData_q;

    logic [7:0]            rxNext;
    logic                  cmdOor;
    logic [ADDR_WIDTH-1:0] idxInc;
    logic                  spiWrEn;

    assign sclkS    = sclkSync_q[SYNC_STAGES-1];
    assign csS      = csSync_q[SYNC_STAGES-1];
    assign sdiS     = sdiSync_q[SYNC_STAGES-1];
    assign sclkRise = sclkS & ~sclkPrev_q;
    assign sclkFall = ~sclkS & sclkPrev_q;
    assign csRise   = csS & ~csPrev_q;
    assign csFall   = ~csS & csPrev_q;

    assign rxNext = {rxShift_q[6:0], sdiS};
    assign cmdOor = ((rxNext[6:0] >> ADDR_WIDTH) != 7'd0);
    assign idxInc = idx_q + IDX_ONE;

    // cs resets high so leaving reset never looks like the start of a transaction
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclkSync_q <= '0;
            csSync_q   <= '1;
            sdiSync_q  <= '0;
            sclkPrev_q <= 1'b0;
            csPrev_q   <= 1'b1;
        end else begin
            sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk_i};
            csSync_q   <= {csSync_q[SYNC_STAGES-2:0], cs_i};
            sdiSync_q  <= {sdiSync_q[SYNC_STAGES-2:0], sdi};
            sclkPrev_q <= sclkS;
            csPrev_q   <= csS;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= WAIT_CS;
            bitCnt_q   <= '0;
            rxShift_q  <= '0;
            txShift_q  <= '0;
            idx_q      <= '0;
            isRead_q   <= 1'b0;
            oor_q      <= 1'b0;
            dataDone_q <= 1'b0;
            sdo_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            rxShift_q  <= rxShift_d;
            txShift_q  <= txShift_d;
            idx_q      <= idx_d;
            isRead_q   <= isRead_d;
            oor_q      <= oor_d;
            dataDone_q <= dataDone_d;
            sdo_q      <= sdo_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        rxShift_d  = rxShift_q;
        txShift_d  = txShift_q;
        idx_d      = idx_q;
        isRead_d   = isRead_q;
        oor_d      = oor_q;
        dataDone_d = dataDone_q;
        sdo_d      = sdo_q;
        done_d     = 1'b0;
        spiWrEn    = 1'b0;

        if (state_q != WAIT_CS && csRise) begin
            state_d    = IDLE;
            bitCnt_d   = '0;
            rxShift_d  = '0;
            txShift_d  = '0;
            sdo_d      = 1'b0;
            done_d     = dataDone_q;
            dataDone_d = 1'b0;
        end else begin
            unique case (state_q)
                WAIT_CS: begin
                    sdo_d = 1'b0;
                    if (csS) state_d = IDLE;
                end
                IDLE: begin
                    if (csFall) begin
                        state_d   = CMD;
                        bitCnt_d  = '0;
                        rxShift_d = '0;
                    end
                end
                CMD: begin
                    if (sclkRise) begin
                        rxShift_d = rxNext;
                        bitCnt_d  = bitCnt_q + 3'd1;
                        if (bitCnt_q == 3'd7) begin
                            isRead_d  = rxNext[7];
                            oor_d     = cmdOor;
                            idx_d     = rxNext[ADDR_WIDTH-1:0];
                            txShift_d = (rxNext[7] && !cmdOor) ? regs_q[rxNext[ADDR_WIDTH-1:0]] : 8'h00;
                            state_d   = DATA;
                        end
                    end
                end
                DATA, EXTRA: begin
                    // In burst mode idx_q always points at the byte currently being shifted,
                    // and read data for the following byte is fetched at the end of this one.
                    if (state_q == DATA || BURST_EN) begin
                        if (sclkFall) begin
                            sdo_d     = isRead_q & txShift_q[7];
                            txShift_d = {txShift_q[6:0], 1'b0};
                        end
                        if (sclkRise) begin
                            rxShift_d = rxNext;
                            bitCnt_d  = bitCnt_q + 3'd1;
                            if (bitCnt_q == 3'd7) begin
                                spiWrEn    = !isRead_q && !oor_q;
                                dataDone_d = 1'b1;
                                state_d    = EXTRA;
                                if (BURST_EN) begin
                                    idx_d     = idxInc;
                                    txShift_d = (isRead_q && !oor_q) ? regs_q[idxInc] : 8'h00;
                                end
                            end
                        end
                    end else if (sclkFall) begin
                        sdo_d = 1'b0;
                    end
                end
                default: state_d = WAIT_CS;
            endcase
        end
    end

    // The SPI write is applied after the local write so it wins on an address collision
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= 8'h00;
            readData_q <= 8'h00;
        end else begin
            if (bus.enable && !bus.write_enable) readData_q <= regs_q[bus.address];
            if (bus.enable && bus.write_enable) regs_q[bus.address] <= bus.write_data;
            if (spiWrEn) regs_q[idx_q] <= rxNext;
        end
    end

    assign bus.read_data = readData_q;
    assign sdo           = sdo_q;
    assign done_int      = done_q;
endmodule

// File: tb/tb_spi_reg_responder.sv
// Self-checking bench for spi_reg_responder: table-driven local bus accesses plus
// hand-written SPI transactions, all results compared through an expectation queue.
module tb_spi_reg_responder;
    localparam int ADDR_WIDTH = 2;
`ifdef SPI_REG_RESPONDER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic sclk = 1'b0;
    logic cs   = 1'b1;
    logic sdi  = 1'b0;
    logic sdo;
    logic doneInt;

    int checkCount = 0;
    int failCount  = 0;
    int doneCount  = 0;
    int doneBase;
    logic [7:0] rxByte;

    logic [7:0] expQ[$];
    string      nameQ[$];

    typedef struct {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            wdata;
        logic [7:0]            expRead;
    } busVec_t;

    busVec_t vecs[11];

    spi_reg_responder_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    spi_reg_responder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .sclk_i  (sclk),
        .cs_i    (cs),
        .sdi     (sdi),
        .sdo     (sdo),
        .done_int(doneInt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (doneInt === 1'b1) doneCount++;

    task automatic expectValue(input string name, input logic [7:0] value);
        expQ.push_back(value);
        nameQ.push_back(name);
    endtask

    task automatic checkOutput(input logic [7:0] actual);
        logic [7:0] exp;
        string      name;
        checkCount++;
        if (expQ.size() == 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard-empty: got %h with nothing expected", actual);
            return;
        end
        exp  = expQ.pop_front();
        name = nameQ.pop_front();
        if (actual !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [ADDR_WIDTH-1:0] addr,
                                 input logic [7:0] wdata, input logic [7:0] expRead);
        @(negedge clk);
        bus.enable       = 1'b1;
        bus.write_enable = we;
        bus.address      = addr;
        bus.write_data   = wdata;
        if (!we) expectValue($sformatf("local-read-reg%0d", addr), expRead);
        @(negedge clk);
        bus.enable       = 1'b0;
        bus.write_enable = 1'b0;
        if (!we) checkOutput(bus.read_data);
    endtask

    task automatic halfWait();
        repeat (8) @(negedge clk);
    endtask

    task automatic spiBits(input logic [7:0] tx, input int nBits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nBits; i--) begin
            sdi = tx[i];
            halfWait();
            sclk  = 1'b1;
            rx[i] = sdo;
            halfWait();
            sclk = 1'b0;
        end
    endtask

    task automatic csStart();
        @(negedge clk);
        cs = 1'b0;
        halfWait();
    endtask

    task automatic csEnd();
        halfWait();
        cs = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic checkDone(input string name, input int expected);
        expectValue(name, 8'(expected));
        checkOutput(8'(doneCount - doneBase));
    endtask

    initial begin
        vecs[0]  = '{1'b0, 2'd0, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 2'd1, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 2'd2, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 2'd3, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 2'd1, 8'h5A, 8'h00};
        vecs[5]  = '{1'b0, 2'd1, 8'h00, 8'h5A};
        vecs[6]  = '{1'b1, 2'd1, 8'h3C, 8'h00};
        vecs[7]  = '{1'b0, 2'd1, 8'h00, 8'h3C};
        vecs[8]  = '{1'b1, 2'd2, 8'hC3, 8'h00};
        vecs[9]  = '{1'b1, 2'd2, 8'h00, 8'h00};
        vecs[10] = '{1'b0, 2'd2, 8'h00, 8'h00};

        bus.enable       = 1'b0;
        bus.write_enable = 1'b0;
        bus.address      = '0;
        bus.write_data   = 8'h00;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        expectValue("reset-sdo", 8'h00);
        checkOutput({7'b0, sdo});
        expectValue("reset-read_data", 8'h00);
        checkOutput(bus.read_data);
        expectValue("reset-done_int", 8'h00);
        checkOutput({7'b0, doneInt});
        rst = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 11; i++)
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].expRead);

        $display("[TB] SPI write 0x02/0xA5");
        doneBase = doneCount;
        csStart();
        spiBits(8'h02, 8, rxByte);
        spiBits(8'hA5, 8, rxByte);
        csEnd();
        checkDone("spi-write-done", 1);
        applyStimulus(1'b0, 2'd2, 8'h00, 8'hA5);

        $display("[TB] SPI read 0x81");
        doneBase = doneCount;
        csStart();
        spiBits(8'h81, 8, rxByte);
        expectValue("read-cmd-sdo-idle", 8'h00);
        checkOutput(rxByte);
        spiBits(8'h00, 8, rxByte);
        expectValue("spi-read-reg1", 8'h3C);
        checkOutput(rxByte);
        csEnd();
        checkDone("spi-read-done", 1);
        applyStimulus(1'b0, 2'd1, 8'h00, 8'h3C);

        $display("[TB] aborted write to reg0");
        doneBase = doneCount;
        csStart();
        spiBits(8'h00, 8, rxByte);
        spiBits(8'h77, 5, rxByte);
        csEnd();
        checkDone("abort-no-done", 0);
        expectValue("abort-sdo", 8'h00);
        checkOutput({7'b0, sdo});
        applyStimulus(1'b0, 2'd0, 8'h00, 8'h00);

        $display("[TB] out-of-range write 0x10/0xFF");
        doneBase = doneCount;
        csStart();
        spiBits(8'h10, 8, rxByte);
        spiBits(8'hFF, 8, rxByte);
        csEnd();
        checkDone("range-write-done", 1);
        applyStimulus(1'b0, 2'd0, 8'h00, 8'h00);
        applyStimulus(1'b0, 2'd1, 8'h00, 8'h3C);
        applyStimulus(1'b0, 2'd2, 8'h00, 8'hA5);
        applyStimulus(1'b0, 2'd3, 8'h00, 8'h00);

        for (int k = 0; k < 2; k++) begin
            csStart();
            spiBits((k == 0) ? 8'h90 : 8'h91, 8, rxByte);
            spiBits(8'h00, 8, rxByte);
            expectValue($sformatf("range-read-%0d", k), 8'h00);
            checkOutput(rxByte);
            csEnd();
        end

        $display("[TB] collision on reg3");
        doneBase = doneCount;
        csStart();
        spiBits(8'h03, 8, rxByte);
        spiBits(8'h11, 7, rxByte);
        sdi = 1'b1;
        halfWait();
        sclk = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.enable       = 1'b1;
        bus.write_enable = 1'b1;
        bus.address      = 2'd3;
        bus.write_data   = 8'h22;
        @(negedge clk);
        bus.enable       = 1'b0;
        bus.write_enable = 1'b0;
        halfWait();
        sclk = 1'b0;
        csEnd();
        checkDone("collision-done", 1);
        applyStimulus(1'b0, 2'd3, 8'h00, 8'h11);

        $display("[TB] burst 0x03/0x11/0x22");
        applyStimulus(1'b1, 2'd3, 8'h00, 8'h00);
        doneBase = doneCount;
        csStart();
        spiBits(8'h03, 8, rxByte);
        spiBits(8'h11, 8, rxByte);
        spiBits(8'h22, 8, rxByte);
        csEnd();
        checkDone("burst-done", 1);
        applyStimulus(1'b0, 2'd3, 8'h00, 8'h11);
        applyStimulus(1'b0, 2'd0, 8'h00, BURST ? 8'h22 : 8'h00);

        csStart();
        spiBits(8'h83, 8, rxByte);
        spiBits(8'h00, 8, rxByte);
        expectValue("burst-read-first", 8'h11);
        checkOutput(rxByte);
        spiBits(8'h00, 8, rxByte);
        expectValue("burst-read-second", BURST ? 8'h22 : 8'h00);
        checkOutput(rxByte);
        csEnd();

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "[TB] timeout");
    end
endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI-side register-file responder that answers transactions issued by the `spi` block running in master mode.
- Shares the `spi` serial pins (sclk_i, cs_i, sdi, sdo) and its local configuration-bus convention (enable, write_enable, address, write_data, read_data).
- Exposes 2**ADDR_WIDTH byte registers to both the SPI master and local logic.
- Pulses done_int when an SPI transaction completes.

Parameters:
- ADDR_WIDTH, 2, register index width; register count REG_COUNT = 2**ADDR_WIDTH.
- SYNC_STAGES, 2, synchronizer depth on sclk_i, cs_i and sdi (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the sclk_i frequency.
- rst  input  1  synchronous, active-low reset.
- enable  input  1  local bus access strobe.
- write_enable  input  1  with enable: 1 = local write, 0 = local read.
- address  input  ADDR_WIDTH  local register index.
- write_data  input  8  local write data.
- read_data  output  8  registered local read data.
- sclk_i  input  1  SPI clock from master; mode 0 (CPOL=0, CPHA=0).
- cs_i  input  1  chip select, active low.
- sdi  input  1  MOSI; MSB first.
- sdo  output  1  MISO; driven 0 whenever no read data is being shifted.
- done_int  output  1  one-clk pulse at end of a valid transaction.

Behaviour:
- **Clock and reset.** One clock, clk. rst is synchronous and active-low.
- **Reset state.** While rst=0 at a clk edge:
  - all registers = 0x00; read_data = 0x00; sdo = 0; done_int = 0.
  - state = WAIT_CS; bit counter and shift registers cleared.
- **Input sampling.** sclk_i, cs_i and sdi pass through SYNC_STAGES flops. Rise/fall of sclk and cs are detected on the synchronized values.
- **Serial timing.**
  - sdi is sampled on the synchronized sclk rising edge.
  - sdo is updated on the synchronized sclk falling edge.
  - Shifting is MSB first.
- **State machine.**
  - WAIT_CS: stay until synchronized cs is high, then go to IDLE. A reset mid-transaction therefore ignores the rest of that transaction.
  - IDLE: cs falling -> CMD; bit counter = 0.
  - CMD: shift 8 bits.
    - Byte fields: bit7 = R/nW (1 = read), bits[6:0] = address.
    - After the 8th rising edge: latch the command. Out-of-range means bits[6:ADDR_WIDTH] != 0.
    - For a read, load the shift-out register with the addressed register (0x00 if out of range). Drive its MSB on sdo at the next sclk falling edge.
    - Go to DATA.
  - DATA: shift 8 bits.
    - Read: the remaining bits of the shift-out register are shifted onto sdo on each falling edge.
    - Write: at the 8th rising edge, write the received byte to the register, unless out of range (then discarded).
    - Set the flag data_done = 1, then go to EXTRA.
  - EXTRA: handling of bytes after the first data byte; see Optional Feature.
  - Any state except WAIT_CS: cs rising -> IDLE.
    - done_int = 1 for one clk if data_done is set; data_done is then cleared.
    - A partial byte is discarded and sdo = 0.
- **Local bus.**
  - enable=1, write_enable=1: write_data -> reg[address] at the clk edge.
  - enable=1, write_enable=0: reg[address] -> read_data one clk later; read_data otherwise holds its value.
- **Write collision.** An SPI write and a local write to the same register in the same clk: the SPI write wins and the local write is dropped. Writes to different registers in the same clk both take effect.
- **Read during write.** A local read in the same clk as any write returns the pre-write value.
- **Read-out snapshot.** For an SPI read, the register value is snapshotted when the command completes. Later local writes do not alter bits already in flight.
- **sclk with cs high.** sclk activity while cs is high is ignored.

Optional Feature:
- Macro: SPI_REG_RESPONDER_BURST_EN.
- **Defined.** In EXTRA, each further complete byte targets address+1.
  - The address wraps from REG_COUNT-1 to 0.
  - Reads reload the shift-out register with the next register value after the 8th rising edge.
  - Writes commit at the 8th rising edge.
  - Out-of-range status is evaluated on the incremented address.
- **Not defined.** In EXTRA, further bytes are ignored: sdo = 0 and no register is written. The transaction still ends normally at cs rising.

Test Plan:
- Reset: rst=0 for 2 clks with cs_i=1 -> sdo=0, read_data=0x00, done_int=0; a local read of each register returns 0x00.
- SPI write: master sends 0x02 then 0xA5, then cs high -> reg2=0xA5 (local read returns 0xA5 one clk after request); exactly one done_int pulse.
- SPI read: local write reg1=0x3C, then master sends 0x81 then 0x00 -> master receives 0x3C in the second byte; reg1 unchanged.
- Abort and range: cs high after 5 bits of the data byte of a write of 0x77 to reg0 -> reg0 unchanged, no done_int. Write 0x10/0xFF -> no register changes; read 0x90 returns 0x00.
- Collision: SPI write 0x11 to reg3 lands in the same clk as a local write of 0x22 to reg3 -> reg3=0x11.
- Burst: master sends 0x03, 0x11, 0x22.
  - With SPI_REG_RESPONDER_BURST_EN: reg3=0x11 and reg0=0x22 (wrap).
  - Without: reg3=0x11 and reg0 unchanged.
  - Both: one done_int.
